sha1_msg_ctrl: RTL and testbench
================================

Name: sha1_msg_ctrl

Overview:
Message-level controller that sequences the sha1_exec compression core. It accepts a big-endian 32-bit word stream and forwards each 16-word block to the core over load_in/data_in. It generates SHA-1 padding and the 64-bit bit-length itself, issues start/use_prev_cv per block, and returns the final 160-bit digest. It sits between a message source (DMA or host FIFO) and a single sha1_exec instance.

Parameters:
GAP_CYCLES, 2, idle cycles between the 16th core_load_in and core_start (legal range 1..15).
IV, 160'h67452301_EFCDAB89_98BADCFE_10325476_C3D2E1F0, initial chaining value driven on core_cv.

Ports:
clk  in  1  clock; all logic on posedge.
reset  in  1  synchronous, active-high reset.
msg_valid  in  1  upstream word valid.
msg_ready  out  1  upstream word accepted when msg_valid & msg_ready.
msg_data  in  32  message word; [31:24] is the first byte.
msg_last  in  1  marks the final word of the message.
msg_last_bytes  in  2  valid bytes in the last word: 0 means 4, 1..3 literal; left-aligned; ignored unless msg_last.
core_load_in  out  1  to sha1_exec load_in.
core_data_in  out  32  to sha1_exec data_in.
core_start  out  1  to sha1_exec start; one-cycle pulse.
core_use_prev_cv  out  1  to sha1_exec use_prev_cv; valid with core_start.
core_cv  out  160  to sha1_exec cv; constant IV.
core_busy  in  1  from sha1_exec busy.
core_out_valid  in  1  from sha1_exec out_valid.
core_cv_next  in  160  from sha1_exec cv_next.
digest  out  160  final hash; held until the next digest_valid.
digest_valid  out  1  one-cycle pulse when digest updates.
busy  out  1  high in every state except IDLE.

Behaviour:
- Reset: state=IDLE; msg_ready=0 during reset and 1 the cycle after; core_load_in=0, core_start=0, core_use_prev_cv=0, core_data_in=0; digest=0; digest_valid=0; word_idx=0; bit_len=0; first_blk=1. Reset mid-operation aborts the hash. No digest_valid is produced. The core is not signalled; its in-flight result is ignored.
- States: IDLE, LOAD, PAD, GAP, START, WAIT, DONE.
- IDLE: msg_ready=1. An accepted word behaves exactly as in LOAD and moves the FSM to LOAD.
- LOAD: msg_ready=1. Each accepted word drives core_load_in=1 with core_data_in=word in the same cycle, increments word_idx, and adds 32 to bit_len.
  - On word_idx==15 with no msg_last: go to GAP.
  - On msg_last with k bytes (1..3): bytes after k are replaced by 0x80 then zeros, bit_len += 8k, and the marker is recorded as placed.
  - On msg_last with k=4: bit_len += 32 and the marker is not yet placed.
  - After msg_last the FSM goes to PAD, or to GAP if the word was at index 15.
- PAD: msg_ready=0. One word per cycle with core_load_in=1:
  - 80000000 if the marker is not yet placed;
  - at index 14/15, bit_len[63:32] and bit_len[31:0] if the marker was placed at index <=13 of this block;
  - otherwise 0.
  - After index 15, go to GAP.
  - Marker at index 14 or 15 forces an extra block of 14 zero words plus the length.
- GAP: core_load_in=0 for GAP_CYCLES cycles, then START.
- START: waits while core_busy=1. Otherwise pulses core_start=1 with core_use_prev_cv=!first_blk, clears first_blk, and goes to WAIT.
- WAIT: waits for core_out_valid.
  - Non-final block: return to LOAD (if more message) or PAD (padding pending); word_idx=0.
  - Final block: go to DONE.
- DONE: capture digest<=core_cv_next one cycle after core_out_valid; digest_valid=1 for that cycle. Then IDLE with first_blk=1 and bit_len=0.
- core_load_in is never asserted between core_start and core_out_valid, nor while core_busy=1.
- bit_len is 64 bits and wraps modulo 2^64. Zero-length messages are not supported; a message is at least 1 byte.
- msg_valid with msg_ready=0 is held by upstream. Data is sampled only on the handshake.

Test Plan:
1. "abc": one word 61626300, last_bytes=3 → words 61626380, 13×0, 00000000, 00000018. One core_start with use_prev_cv=0; digest a9993e36_4706816a_ba3e2571_7850c26c_9cd0d89d.
2. 56-byte "abcdbcdecdef…nopq": 14 words, last_bytes=0 → block 1 ends 80000000, 0; block 2 is 14×0, 0, 000001C0. Second start has use_prev_cv=1; digest 84983e44_1c3bd26e_baae4aa1_f95129e5_e54670f1.
3. 64 bytes (16 full words) → two blocks; block 2 = 80000000, 13×0, 0, 00000200. Exactly two core_start pulses; digest_valid once.
4. 55-byte message (last_bytes=3) → single block, marker in word 13, length 000001B8 at words 14/15; one core_start.
5. "a" (61000000, last_bytes=1) with msg_valid toggled every other cycle and core_busy held high 5 cycles past out_valid → core_start waits for busy=0; no load while busy; digest 86f7e437_faa5a7fc_e15d1ddc_b9eaeaea_377667b8.
6. Reset asserted during WAIT → next cycle IDLE, no digest_valid, digest=0; a following "abc" gives the test-1 digest with use_prev_cv=0.

Source files
------------

// File: rtl/sha1_msg_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : sha1_msg_ctrl
// Description : Message-level sequencer for one sha1_exec compression core.
//               Accepts a big-endian 32-bit word stream and forwards each
//               16-word block to the core. Appends the SHA-1 0x80 marker, the
//               zero fill and the 64-bit bit length. Issues start/use_prev_cv
//               for each block and returns the final 160-bit digest.
// Ports       : clk, reset                 - clock, sync active-high reset
//               msg_valid/ready/data/last,
//               msg_last_bytes             - upstream word stream
//               core_load_in/data_in/start,
//               core_use_prev_cv, core_cv  - to sha1_exec
//               core_busy/out_valid/cv_next - from sha1_exec
//               digest, digest_valid       - final hash + update pulse
//               busy                       - controller not idle
// Revision    : 1.0 - initial release
// ============================================================================
module sha1_msg_ctrl #(
    parameter int           GAP_CYCLES = 2,
    parameter logic [159:0] IV         = 160'h67452301_EFCDAB89_98BADCFE_10325476_C3D2E1F0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         msg_valid,
    output logic         msg_ready,
    input  logic [31:0]  msg_data,
    input  logic         msg_last,
    input  logic [1:0]   msg_last_bytes,
    output logic         core_load_in,
    output logic [31:0]  core_data_in,
    output logic         core_start,
    output logic         core_use_prev_cv,
    output logic [159:0] core_cv,
    input  logic         core_busy,
    input  logic         core_out_valid,
    input  logic [159:0] core_cv_next,
    output logic [159:0] digest,
    output logic         digest_valid,
    output logic         busy
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_PAD   = 3'd2,
        S_GAP   = 3'd3,
        S_START = 3'd4,
        S_WAIT  = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    localparam logic [3:0]  C_GAP_LAST  = 4'(GAP_CYCLES - 1);
    localparam logic [31:0] C_MARKER    = 32'h8000_0000;
    localparam logic [3:0]  C_LAST_IDX  = 4'd15;
    localparam logic [3:0]  C_LEN_HI    = 4'd14;
    localparam logic [3:0]  C_LEN_ROOM  = 4'd13;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t         state_q,     state_d;
    logic [3:0]     word_idx_q,  word_idx_d;
    logic [63:0]    bit_len_q,   bit_len_d;
    logic           first_blk_q, first_blk_d;
    logic           marker_q,    marker_d;    // 0x80 marker already emitted
    logic           len_ok_q,    len_ok_d;    // length fits in current block
    logic           last_q,      last_d;      // msg_last has been accepted
    logic           final_q,     final_d;     // current block carries length
    logic [3:0]     gap_cnt_q,   gap_cnt_d;
    logic [159:0]   digest_q,    digest_d;

    logic           w_msg_ready;
    logic           w_load;
    logic [31:0]    w_data;
    logic           w_start;

    // Last-word byte masking: a partial last word keeps its first k bytes,
    // the next byte becomes the 0x80 marker and the rest are zero.
    logic           w_partial;
    logic [31:0]    w_masked;

    always_comb begin
        w_partial = msg_last && (msg_last_bytes != 2'd0);
        w_masked  = msg_data;
        if (w_partial) begin
            case (msg_last_bytes)
                2'd1:    w_masked = {msg_data[31:24], 8'h80, 16'h0000};
                2'd2:    w_masked = {msg_data[31:16], 8'h80, 8'h00};
                2'd3:    w_masked = {msg_data[31:8],  8'h80};
                default: w_masked = msg_data;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Next-state / output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        word_idx_d  = word_idx_q;
        bit_len_d   = bit_len_q;
        first_blk_d = first_blk_q;
        marker_d    = marker_q;
        len_ok_d    = len_ok_q;
        last_d      = last_q;
        final_d     = final_q;
        gap_cnt_d   = gap_cnt_q;
        digest_d    = digest_q;
        w_msg_ready = 1'b0;
        w_load      = 1'b0;
        w_data      = 32'd0;
        w_start     = 1'b0;

        case (state_q)
            // IDLE and LOAD share the word-accept path. Acceptance is held
            // off while the core is busy so no load can overlap a run.
            S_IDLE, S_LOAD: begin
                w_msg_ready = !core_busy;
                if (msg_valid && w_msg_ready) begin
                    w_load     = 1'b1;
                    w_data     = w_masked;
                    word_idx_d = word_idx_q + 4'd1;
                    last_d     = msg_last;
                    if (w_partial) begin
                        bit_len_d = bit_len_q + {58'd0, msg_last_bytes, 3'd0};
                        marker_d  = 1'b1;
                        len_ok_d  = (word_idx_q <= C_LEN_ROOM);
                    end else begin
                        bit_len_d = bit_len_q + 64'd32;
                    end
                    if (word_idx_q == C_LAST_IDX) begin
                        state_d = S_GAP;
                    end else if (msg_last) begin
                        state_d = S_PAD;
                    end else begin
                        state_d = S_LOAD;
                    end
                end
            end

            // Fill the block: marker first if still owed, then zeros, and
            // the 64-bit length in the last two slots when it fits here.
            S_PAD: begin
                if (!core_busy) begin
                    w_load     = 1'b1;
                    word_idx_d = word_idx_q + 4'd1;
                    if (!marker_q) begin
                        w_data   = C_MARKER;
                        marker_d = 1'b1;
                        len_ok_d = (word_idx_q <= C_LEN_ROOM);
                    end else if (len_ok_q && (word_idx_q == C_LEN_HI)) begin
                        w_data = bit_len_q[63:32];
                    end else if (len_ok_q && (word_idx_q == C_LAST_IDX)) begin
                        w_data  = bit_len_q[31:0];
                        final_d = 1'b1;
                    end
                    if (word_idx_q == C_LAST_IDX) begin
                        state_d = S_GAP;
                    end
                end
            end

            S_GAP: begin
                if (gap_cnt_q == C_GAP_LAST) begin
                    gap_cnt_d = 4'd0;
                    state_d   = S_START;
                end else begin
                    gap_cnt_d = gap_cnt_q + 4'd1;
                end
            end

            S_START: begin
                if (!core_busy) begin
                    w_start     = 1'b1;
                    first_blk_d = 1'b0;
                    state_d     = S_WAIT;
                end
            end

            // A non-final block after msg_last still owes padding; an extra
            // block whose marker landed earlier always has room for length.
            S_WAIT: begin
                if (core_out_valid) begin
                    word_idx_d = 4'd0;
                    if (final_q) begin
                        digest_d = core_cv_next;
                        state_d  = S_DONE;
                    end else if (last_q) begin
                        len_ok_d = marker_q;
                        state_d  = S_PAD;
                    end else begin
                        state_d  = S_LOAD;
                    end
                end
            end

            S_DONE: begin
                state_d     = S_IDLE;
                first_blk_d = 1'b1;
                bit_len_d   = 64'd0;
                word_idx_d  = 4'd0;
                marker_d    = 1'b0;
                len_ok_d    = 1'b0;
                last_d      = 1'b0;
                final_d     = 1'b0;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            word_idx_q  <= 4'd0;
            bit_len_q   <= 64'd0;
            first_blk_q <= 1'b1;
            marker_q    <= 1'b0;
            len_ok_q    <= 1'b0;
            last_q      <= 1'b0;
            final_q     <= 1'b0;
            gap_cnt_q   <= 4'd0;
            digest_q    <= 160'd0;
        end else begin
            state_q     <= state_d;
            word_idx_q  <= word_idx_d;
            bit_len_q   <= bit_len_d;
            first_blk_q <= first_blk_d;
            marker_q    <= marker_d;
            len_ok_q    <= len_ok_d;
            last_q      <= last_d;
            final_q     <= final_d;
            gap_cnt_q   <= gap_cnt_d;
            digest_q    <= digest_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: strobes are forced low while reset is held so nothing
    // reaches the core or upstream during the reset cycle itself.
    // ------------------------------------------------------------------
    assign msg_ready        = w_msg_ready & ~reset;
    assign core_load_in     = w_load & ~reset;
    assign core_data_in     = reset ? 32'd0 : w_data;
    assign core_start       = w_start & ~reset;
    assign core_use_prev_cv = w_start & ~reset & ~first_blk_q;
    assign core_cv          = IV;
    assign digest           = digest_q;
    assign digest_valid     = (state_q == S_DONE) & ~reset;
    assign busy             = (state_q != S_IDLE) & ~reset;

endmodule
`default_nettype wire

// File: tb/tb_sha1_msg_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_sha1_msg_ctrl
// Description : Directed self-checking bench for sha1_msg_ctrl with a
//               behavioural sha1_exec responder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sha1_msg_ctrl;

    localparam logic [159:0] C_IV = 160'h67452301_EFCDAB89_98BADCFE_10325476_C3D2E1F0;

    logic         clk = 1'b0;
    logic         reset;
    logic         msg_valid;
    logic         msg_ready;
    logic [31:0]  msg_data;
    logic         msg_last;
    logic [1:0]   msg_last_bytes;
    logic         core_load_in;
    logic [31:0]  core_data_in;
    logic         core_start;
    logic         core_use_prev_cv;
    logic [159:0] core_cv;
    logic         core_busy;
    logic         core_out_valid;
    logic [159:0] core_cv_next;
    logic [159:0] digest;
    logic         digest_valid;
    logic         busy;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    sha1_msg_ctrl #(.GAP_CYCLES(2), .IV(C_IV)) dut (
        .clk              (clk),
        .reset            (reset),
        .msg_valid        (msg_valid),
        .msg_ready        (msg_ready),
        .msg_data         (msg_data),
        .msg_last         (msg_last),
        .msg_last_bytes   (msg_last_bytes),
        .core_load_in     (core_load_in),
        .core_data_in     (core_data_in),
        .core_start       (core_start),
        .core_use_prev_cv (core_use_prev_cv),
        .core_cv          (core_cv),
        .core_busy        (core_busy),
        .core_out_valid   (core_out_valid),
        .core_cv_next     (core_cv_next),
        .digest           (digest),
        .digest_valid     (digest_valid),
        .busy             (busy)
    );

    // ------------------------------------------------------------------
    // Reference SHA-1 compression
    // ------------------------------------------------------------------
    function automatic logic [159:0] sha1_f(input logic [159:0] cv, input logic [511:0] blk);
        logic [31:0] w [80];
        logic [31:0] a, b, c, d, e, f, k, t, x;
        for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
        for (int i = 16; i < 80; i++) begin
            x = w[i-3] ^ w[i-8] ^ w[i-14] ^ w[i-16];
            w[i] = {x[30:0], x[31]};
        end
        a = cv[159:128]; b = cv[127:96]; c = cv[95:64]; d = cv[63:32]; e = cv[31:0];
        for (int i = 0; i < 80; i++) begin
            if (i < 20)      begin f = (b & c) | (~b & d);          k = 32'h5A827999; end
            else if (i < 40) begin f = b ^ c ^ d;                   k = 32'h6ED9EBA1; end
            else if (i < 60) begin f = (b & c) | (b & d) | (c & d); k = 32'h8F1BBCDC; end
            else             begin f = b ^ c ^ d;                   k = 32'hCA62C1D6; end
            t = {a[26:0], a[31:27]} + f + e + k + w[i];
            e = d; d = c; c = {b[1:0], b[31:2]}; b = a; a = t;
        end
        return {cv[159:128] + a, cv[127:96] + b, cv[95:64] + c, cv[63:32] + d, cv[31:0] + e};
    endfunction

    // ------------------------------------------------------------------
    // Behavioural sha1_exec responder and protocol monitor
    // ------------------------------------------------------------------
    logic         busy_r = 1'b0;
    logic         ov_r   = 1'b0;
    logic [159:0] cvn_r  = 160'd0;
    logic         busy_force = 1'b0;
    int           busy_hold  = 0;

    logic [511:0] m_blk = 512'd0;
    logic [159:0] m_prev = 160'd0;
    logic [159:0] m_res  = 160'd0;
    logic [3:0]   m_widx = 4'd0;
    bit           m_inflight = 1'b0;
    int           m_cnt  = 0;
    int           m_hold = 0;

    logic [31:0]  words [$];
    bit           useprev [$];
    int           starts    = 0;
    int           dv_count  = 0;
    int           proto_err = 0;

    assign core_busy      = busy_r | busy_force;
    assign core_out_valid = ov_r;
    assign core_cv_next   = cvn_r;

    always @(posedge clk) begin
        ov_r <= 1'b0;
        if (digest_valid) dv_count++;
        if (core_load_in) begin
            if (core_busy || m_inflight) proto_err++;
            m_blk[511 - 32*m_widx -: 32] = core_data_in;
            m_widx = m_widx + 4'd1;
            words.push_back(core_data_in);
        end
        if (core_start) begin
            if (core_busy) proto_err++;
            starts++;
            useprev.push_back(core_use_prev_cv);
            m_res      = sha1_f(core_use_prev_cv ? m_prev : core_cv, m_blk);
            m_prev     = m_res;
            m_widx     = 4'd0;
            m_inflight = 1'b1;
            m_cnt      = 8;
            busy_r    <= 1'b1;
        end else if (m_inflight) begin
            m_cnt--;
            if (m_cnt == 0) begin
                ov_r       <= 1'b1;
                cvn_r      <= m_res;
                m_inflight = 1'b0;
                m_hold     = busy_hold;
                if (busy_hold == 0) busy_r <= 1'b0;
            end
        end else if (busy_r) begin
            if (m_hold <= 1) busy_r <= 1'b0;
            m_hold--;
        end
    end

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [31:0] d, input logic last, input logic [1:0] lb, input bit gap_after);
        int n;
        n = 0;
        msg_valid = 1'b1; msg_data = d; msg_last = last; msg_last_bytes = lb;
        while (!msg_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) check("send_ready_timeout", {159'd0, msg_ready}, 160'd1);
        @(posedge clk);
        @(negedge clk);
        msg_valid = 1'b0; msg_last = 1'b0; msg_last_bytes = 2'd0;
        if (gap_after) @(negedge clk);
    endtask

    task automatic wait_digest(input string tag, input logic [159:0] exp);
        int n;
        n = 0;
        while (!digest_valid && n < 600) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_dv"}, {159'd0, digest_valid}, 160'd1);
        check({tag, "_digest"}, digest, exp);
        @(negedge clk);
    endtask

    task automatic check_words(input string tag, input int base, input logic [31:0] exp [$]);
        check({tag, "_nwords"}, 160'(words.size() - base), 160'(exp.size()));
        for (int i = 0; i < exp.size(); i++) begin
            if (base + i < words.size())
                check({tag, "_word"}, {128'd0, words[base + i]}, {128'd0, exp[i]});
        end
    endtask

    function automatic logic [511:0] pack(input logic [31:0] q [$], input int base);
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[511 - 32*i -: 32] = q[base + i];
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    logic [31:0] exp_w [$];
    int bw, bs, bd;
    logic [159:0] exp_d;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; msg_valid = 1'b0; msg_data = 32'd0; msg_last = 1'b0; msg_last_bytes = 2'd0;
        repeat (3) @(negedge clk);
        check("rst_msg_ready", {159'd0, msg_ready}, 160'd0);
        check("rst_load", {159'd0, core_load_in}, 160'd0);
        check("rst_start", {159'd0, core_start}, 160'd0);
        check("rst_data", {128'd0, core_data_in}, 160'd0);
        check("rst_digest", digest, 160'd0);
        check("rst_dv", {159'd0, digest_valid}, 160'd0);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_ready", {159'd0, msg_ready}, 160'd1);
        check("post_rst_busy", {159'd0, busy}, 160'd0);
        check("core_cv_iv", core_cv, C_IV);

        // 1: "abc"
        bw = words.size(); bs = starts; bd = dv_count;
        send(32'h61626300, 1'b1, 2'd3, 1'b0);
        wait_digest("t1", 160'ha9993e36_4706816a_ba3e2571_7850c26c_9cd0d89d);
        exp_w.delete();
        exp_w.push_back(32'h61626380);
        for (int i = 0; i < 14; i++) exp_w.push_back(32'h0);
        exp_w.push_back(32'h00000018);
        check_words("t1", bw, exp_w);
        check("t1_starts", 160'(starts - bs), 160'd1);
        check("t1_useprev", {159'd0, useprev[bs]}, 160'd0);
        check("t1_dvcount", 160'(dv_count - bd), 160'd1);
        check("t1_idle", {159'd0, busy}, 160'd0);

        // 2: 56-byte message, length spills into a second block
        bw = words.size(); bs = starts; bd = dv_count;
        exp_w.delete();
        exp_w = '{32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                  32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                  32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                  32'h6d6e6f70, 32'h6e6f7071};
        for (int i = 0; i < 14; i++) send(exp_w[i], i == 13, 2'd0, 1'b0);
        wait_digest("t2", 160'h84983e44_1c3bd26e_baae4aa1_f95129e5_e54670f1);
        exp_w.push_back(32'h80000000);
        exp_w.push_back(32'h0);
        for (int i = 0; i < 15; i++) exp_w.push_back(32'h0);
        exp_w.push_back(32'h000001C0);
        check_words("t2", bw, exp_w);
        check("t2_starts", 160'(starts - bs), 160'd2);
        check("t2_useprev0", {159'd0, useprev[bs]}, 160'd0);
        check("t2_useprev1", {159'd0, useprev[bs + 1]}, 160'd1);

        // 3: exactly 64 bytes
        bw = words.size(); bs = starts; bd = dv_count;
        exp_w.delete();
        for (int i = 0; i < 16; i++) exp_w.push_back(32'h30313233 + 32'(i) * 32'h04040404);
        for (int i = 0; i < 16; i++) send(exp_w[i], i == 15, 2'd0, 1'b0);
        exp_w.push_back(32'h80000000);
        for (int i = 0; i < 14; i++) exp_w.push_back(32'h0);
        exp_w.push_back(32'h00000200);
        exp_d = sha1_f(sha1_f(C_IV, pack(exp_w, 0)), pack(exp_w, 16));
        wait_digest("t3", exp_d);
        check_words("t3", bw, exp_w);
        check("t3_starts", 160'(starts - bs), 160'd2);
        check("t3_dvcount", 160'(dv_count - bd), 160'd1);

        // 4: 55 bytes, marker in word 13, length fits
        bw = words.size(); bs = starts;
        exp_w.delete();
        for (int i = 0; i < 13; i++) send(32'h41414141, 1'b0, 2'd0, 1'b0);
        send(32'h41414199, 1'b1, 2'd3, 1'b0);
        for (int i = 0; i < 13; i++) exp_w.push_back(32'h41414141);
        exp_w.push_back(32'h41414180);
        exp_w.push_back(32'h0);
        exp_w.push_back(32'h000001B8);
        exp_d = sha1_f(C_IV, pack(exp_w, 0));
        wait_digest("t4", exp_d);
        check_words("t4", bw, exp_w);
        check("t4_starts", 160'(starts - bs), 160'd1);

        // 5: "a" with upstream gaps and a busy core
        bw = words.size(); bs = starts;
        @(negedge clk);
        send(32'h61AABBCC, 1'b1, 2'd1, 1'b1);
        busy_force = 1'b1;
        repeat (20) @(negedge clk);
        check("t5_stall_starts", 160'(starts - bs), 160'd0);
        check("t5_stall_words", 160'(words.size() - bw), 160'd2);
        busy_hold  = 5;
        busy_force = 1'b0;
        wait_digest("t5", 160'h86f7e437_faa5a7fc_e15d1ddc_b9eaeaea_377667b8);
        check("t5_ready_while_busy", {159'd0, msg_ready}, 160'd0);
        repeat (6) @(negedge clk);
        check("t5_ready_after_busy", {159'd0, msg_ready}, 160'd1);
        check("t5_first_word", {128'd0, words[bw]}, {128'd0, 32'h61800000});
        check("t5_starts", 160'(starts - bs), 160'd1);
        busy_hold = 0;

        // 6: reset while waiting for the core
        bs = starts; bd = dv_count;
        send(32'h61626300, 1'b1, 2'd3, 1'b0);
        for (int n = 0; n < 300 && starts == bs; n++) @(negedge clk);
        repeat (2) @(negedge clk);
        check("t6_in_wait", {159'd0, busy}, 160'd1);
        reset = 1'b1;
        @(negedge clk);
        check("t6_rst_busy", {159'd0, busy}, 160'd0);
        check("t6_rst_digest", digest, 160'd0);
        check("t6_rst_dv", {159'd0, digest_valid}, 160'd0);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        check("t6_no_dv", 160'(dv_count - bd), 160'd0);
        check("t6_digest_held", digest, 160'd0);
        bs = starts;
        send(32'h61626300, 1'b1, 2'd3, 1'b0);
        wait_digest("t6", 160'ha9993e36_4706816a_ba3e2571_7850c26c_9cd0d89d);
        check("t6_useprev", {159'd0, useprev[bs]}, 160'd0);

        check("protocol", 160'(proto_err), 160'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
